uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single 32-bit-word UART transmitter among three sources: the ID responder, a metadata word stream and the captured-sample word stream. It issues exactly one `write` or `id` request at a time, honours the transmitter's `busy` flag, and round-robins between the metadata and sample streams so neither starves. It sits between the command decoder / sample readout logic and the UART transmitter, in the same clock domain.

## Interface

- `RR_INIT`, default 0: stream granted first after reset when both are valid (0 = metadata, 1 = sample).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  when low, no new grant starts; an in-flight word completes.
- `id_req`  in  1  single-cycle request to send the ID word.
- `meta_valid`  in  1  metadata word available.
- `meta_data`  in  32  metadata word.
- `meta_ready`  out  1  metadata word accepted this cycle.
- `smp_valid`  in  1  sample word available.
- `smp_data`  in  32  sample word.
- `smp_disabled`  in  4  per-byte disable mask for the sample word.
- `smp_ready`  out  1  sample word accepted this cycle.
- `tx_busy`  in  1  transmitter busy flag.
- `tx_write`  out  1  word write strobe to the transmitter.
- `tx_wrdata`  out  32  word to the transmitter.
- `tx_disabledGroups`  out  4  byte disable mask to the transmitter.
- `tx_id`  out  1  ID send strobe to the transmitter.
- `arb_idle`  out  1  high in IDLE with no pending ID and no valid stream.

## Operation

- `id_pend` flag: set by `id_req`, cleared when the ID is granted. Set wins on the same edge, so an ID request is never lost. Repeated `id_req` before a grant merges into one send.
- States:
  - IDLE: grant when `enable && !tx_busy && (id_pend || meta_valid || smp_valid)`. Priority: `id_pend` first, then the round-robin choice between meta and sample.
    - `rr` = 0 prefers meta, `rr` = 1 prefers sample. If only one stream is valid, that stream is granted.
    - After a stream grant, `rr` points to the other stream. ID grants leave `rr` unchanged.
    - Grant edge: go to ISSUE.
  - ISSUE: the strobe is high for this single cycle. Go to DRAIN.
  - DRAIN: wait for `tx_busy` == 0, then go to IDLE.
- `meta_ready` / `smp_ready` are combinational. Each is high only in IDLE on the cycle its stream is granted, so valid&ready is the transfer.
- Grant edge register loads:
  - Meta grant: `tx_wrdata` ← `meta_data`, `tx_disabledGroups` ← 4'h0, `tx_write` ← 1.
  - Sample grant: `tx_wrdata` ← `smp_data`, `tx_disabledGroups` ← `smp_disabled`, `tx_write` ← 1.
  - ID grant: `tx_id` ← 1, `tx_write` ← 0, data registers unchanged.
- `tx_write` and `tx_id` are never high together and never high outside ISSUE.
- Valid sources must hold data stable until ready. The arbiter never drops a valid word.

## Timing

- Reset values: `tx_write` = 0, `tx_id` = 0, `tx_wrdata` = 0, `tx_disabledGroups` = 0, `meta_ready` = 0, `smp_ready` = 0, `arb_idle` = 1. Internal: state IDLE, `id_pend` = 0, `rr` = `RR_INIT`.
- Latency: a grant in cycle N puts the strobe in cycle N+1. Earliest next grant is the first cycle after `tx_busy` is seen low in DRAIN.
- The transmitter raises `tx_busy` one cycle after the strobe. DRAIN is entered at N+2, when `tx_busy` is already high. No extra guard cycle.
- `tx_busy` held high by xoff simply extends DRAIN.
- `enable` falling in ISSUE/DRAIN: the word completes, then the arbiter stays in IDLE.
- Reset mid-word: all outputs return immediately to reset values and pending state is discarded.

## Configuration

- `UART_TX_ARB_STATS_EN` defined adds ports:
  - `stats_clr` (in, 1): synchronous clear, wins over increment.
  - `meta_cnt` (out, 16), `smp_cnt` (out, 16), `id_cnt` (out, 8): saturating grant counters, reset 0, incremented on the grant edge.
- Undefined: these ports and counters are absent. Arbitration is identical.

## Test plan

- After reset with `id_req` pulsed, `tx_busy` = 0 → `tx_id` high exactly 2 cycles later for 1 cycle, `tx_write` stays 0. Holding `tx_busy` high 20 cycles then low → next grant the cycle after.
- `meta_valid` and `smp_valid` both held, `RR_INIT` = 0, `tx_busy` modelled as 10 cycles per word → grant order M,S,M,S. `smp_disabled` = 4'b0110 appears on `tx_disabledGroups` for S words, 4'h0 for M words.
- `id_req` during the DRAIN of a meta word with sample pending → ID is sent before the sample word, and `rr` is unchanged.
- `id_req` pulsed twice before any grant → exactly one `tx_id`. `id_req` on the grant edge → a second `tx_id` follows.
- `enable` dropped during ISSUE with `smp_valid` = 1 → current word completes, no `smp_ready` while `enable` is low, resumes one cycle after `enable` returns.
- With `UART_TX_ARB_STATS_EN`: 3 meta, 2 sample and 1 ID words → `meta_cnt` = 3, `smp_cnt` = 2, `id_cnt` = 1. Then `stats_clr` → all 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares the UART word transmitter between ID, metadata and sample sources
// Optional grant counters and stats_clr port: define UART_TX_ARB_STATS_EN
module uart_tx_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        id_req,
    input  logic        meta_valid,
    input  logic [31:0] meta_data,
    output logic        meta_ready,
    input  logic        smp_valid,
    input  logic [31:0] smp_data,
    input  logic [3:0]  smp_disabled,
    output logic        smp_ready,
    input  logic        tx_busy,
    output logic        tx_write,
    output logic [31:0] tx_wrdata,
    output logic [3:0]  tx_disabledGroups,
    output logic        tx_id,
    output logic        arb_idle
`ifdef UART_TX_ARB_STATS_EN
    ,
    input  logic        stats_clr,
    output logic [15:0] meta_cnt,
    output logic [15:0] smp_cnt,
    output logic [7:0]  id_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   id_pend;
    logic   rr;
    logic   grant_id;
    logic   grant_meta;
    logic   grant_smp;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and grant decision: pending ID first, then round-robin between streams
    always_comb begin
        next_state = state;
        grant_id   = 1'b0;
        grant_meta = 1'b0;
        grant_smp  = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && !tx_busy) begin
                    if (id_pend) begin
                        grant_id   = 1'b1;
                        next_state = S_ISSUE;
                    end else if (meta_valid && (!smp_valid || !rr)) begin
                        grant_meta = 1'b1;
                        next_state = S_ISSUE;
                    end else if (smp_valid) begin
                        grant_smp  = 1'b1;
                        next_state = S_ISSUE;
                    end
                end
            end
            S_ISSUE: next_state = S_DRAIN;
            S_DRAIN: begin
                if (!tx_busy) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Ready is the grant itself; held low while reset is asserted
    assign meta_ready = grant_meta && !rst;
    assign smp_ready  = grant_smp && !rst;
    assign arb_idle   = (state == S_IDLE) && !id_pend && !meta_valid && !smp_valid;

    // Pending ID flag (a new request wins over the clear) and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pend <= 1'b0;
            rr      <= RR_INIT;
        end else begin
            id_pend <= id_req || (id_pend && !grant_id);
            if (grant_meta) begin
                rr <= 1'b1;
            end else if (grant_smp) begin
                rr <= 1'b0;
            end
        end
    end

    // Transmitter-side registers: strobes last exactly the ISSUE cycle, data loads on a stream grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_write          <= 1'b0;
            tx_id             <= 1'b0;
            tx_wrdata         <= 32'h0;
            tx_disabledGroups <= 4'h0;
        end else begin
            tx_write <= grant_meta || grant_smp;
            tx_id    <= grant_id;
            if (grant_meta) begin
                tx_wrdata         <= meta_data;
                tx_disabledGroups <= 4'h0;
            end else if (grant_smp) begin
                tx_wrdata         <= smp_data;
                tx_disabledGroups <= smp_disabled;
            end
        end
    end

`ifdef UART_TX_ARB_STATS_EN
    // Saturating grant counters; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_cnt <= 16'h0;
            smp_cnt  <= 16'h0;
            id_cnt   <= 8'h0;
        end else if (stats_clr) begin
            meta_cnt <= 16'h0;
            smp_cnt  <= 16'h0;
            id_cnt   <= 8'h0;
        end else begin
            if (grant_meta && (meta_cnt != 16'hFFFF)) begin
                meta_cnt <= meta_cnt + 16'd1;
            end
            if (grant_smp && (smp_cnt != 16'hFFFF)) begin
                smp_cnt <= smp_cnt + 16'd1;
            end
            if (grant_id && (id_cnt != 8'hFF)) begin
                id_cnt <= id_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
